// File: rtl/fifth_io_pkg.sv
// Shared constants for the fifth core data-memory responder:
// I/O page addresses, status bit positions and the TX state encoding.
package fifth_io_pkg;

   localparam logic [15:0] UART_DATA = 16'hF000;
   localparam logic [15:0] UART_STAT = 16'hF002;
   localparam logic [15:0] TICK      = 16'hF004;
   localparam logic [15:0] LED       = 16'hF006;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVR   = 3;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/fifth_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser.
// The line is a flop so nothing combinational reaches the pin.
module fifth_uart_tx
   import fifth_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_AW      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_clr_overrun,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_busy,
   output logic       o_overrun,
   output logic       o_tx
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]      BAUD_TOP = BW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wp;
   logic [FIFO_AW-1:0] r_rp;
   logic [FIFO_AW:0]   r_cnt;
   logic               r_ovr;

   tx_state_t          r_state;
   tx_state_t          w_state_n;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_n;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_n;
   logic [BW-1:0]      r_baud;
   logic [BW-1:0]      w_baud_n;
   logic               r_tx;
   logic               w_tx_n;

   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push_ok;
   logic               w_baud_zero;

   assign w_full      = (r_cnt == CNT_FULL);
   assign w_empty     = (r_cnt == '0);
   assign w_push_ok   = i_push && (!w_full || w_pop);
   assign w_baud_zero = (r_baud == '0);

   // FIFO storage; contents need no reset, the pointers define validity
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wp] <= i_data;
   end

   // FIFO pointers and occupancy; a pop frees room for a same-edge push
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + 1'b1;
         if (w_pop)     r_rp <= r_rp + 1'b1;
         if (w_push_ok && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (!w_push_ok && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end

   // Sticky overrun: a dropped push sets it, a clear request drops it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           r_ovr <= 1'b0;
      else if (i_push && w_full && !w_pop)  r_ovr <= 1'b1;
      else if (i_clr_overrun)               r_ovr <= 1'b0;
   end

   // Serialiser state, shifter, bit/baud counters and line register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= TX_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_baud  <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_shift <= w_shift_n;
         r_bit   <= w_bit_n;
         r_baud  <= w_baud_n;
         r_tx    <= w_tx_n;
      end
   end

   // Next-state, pop request and next line level
   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_bit_n   = r_bit;
      w_baud_n  = r_baud;
      w_tx_n    = r_tx;
      w_pop     = 1'b0;
      unique case (r_state)
         TX_IDLE: begin
            w_tx_n = 1'b1;
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_shift_n = r_mem[r_rp];
               w_baud_n  = BAUD_TOP;
               w_tx_n    = 1'b0;
               w_state_n = TX_START;
            end
         end
         TX_START: begin
            if (w_baud_zero) begin
               w_baud_n  = BAUD_TOP;
               w_bit_n   = '0;
               w_tx_n    = r_shift[0];
               w_state_n = TX_DATA;
            end else begin
               w_baud_n = r_baud - 1'b1;
            end
         end
         TX_DATA: begin
            if (w_baud_zero) begin
               w_baud_n = BAUD_TOP;
               if (r_bit == 3'd7) begin
                  w_tx_n    = 1'b1;
                  w_state_n = TX_STOP;
               end else begin
                  w_bit_n   = r_bit + 1'b1;
                  w_shift_n = {1'b0, r_shift[7:1]};
                  w_tx_n    = r_shift[1];
               end
            end else begin
               w_baud_n = r_baud - 1'b1;
            end
         end
         TX_STOP: begin
            if (w_baud_zero) begin
               if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_shift_n = r_mem[r_rp];
                  w_baud_n  = BAUD_TOP;
                  w_tx_n    = 1'b0;
                  w_state_n = TX_START;
               end else begin
                  w_tx_n    = 1'b1;
                  w_state_n = TX_IDLE;
               end
            end else begin
               w_baud_n = r_baud - 1'b1;
            end
         end
         default: w_state_n = TX_IDLE;
      endcase
   end

   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_busy    = (r_state != TX_IDLE);
   assign o_overrun = r_ovr;
   assign o_tx      = r_tx;

endmodule

// File: rtl/fifth_memio.sv
// Data-port responder for the fifth core: RAM plus an I/O page
// (UART TX, tick counter, LEDs) with one-cycle registered reads.
module fifth_memio
   import fifth_io_pkg::*;
#(
   parameter int RAM_AW       = 13,
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_AW      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        uart_tx,
   output logic [7:0]  led
);

   logic [15:0]       r_ram [1 << RAM_AW];
   logic [15:0]       r_ram_q;
   logic              r_sel_ram;
   logic [15:0]       r_io_q;
   logic [15:0]       r_tick;
   logic [7:0]        r_led;
   logic [15:0]       w_stat;

   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_is_ram;
   logic              w_is_data;
   logic              w_is_stat;
   logic              w_is_tick;
   logic              w_is_led;
   logic              w_full;
   logic              w_empty;
   logic              w_busy;
   logic              w_ovr;
   logic              w_unused_a0;

   assign w_ram_idx   = cpu_addr[RAM_AW:1];
   assign w_is_ram    = !cpu_addr[15];
   assign w_is_data   = (cpu_addr[15:1] == UART_DATA[15:1]);
   assign w_is_stat   = (cpu_addr[15:1] == UART_STAT[15:1]);
   assign w_is_tick   = (cpu_addr[15:1] == TICK[15:1]);
   assign w_is_led    = (cpu_addr[15:1] == LED[15:1]);
   assign w_unused_a0 = cpu_addr[0];

   fifth_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .FIFO_AW      (FIFO_AW)
   ) u_tx (
      .clk           (clk),
      .reset         (reset),
      .i_push        (cpu_we && w_is_data),
      .i_data        (cpu_wdata[7:0]),
      .i_clr_overrun (cpu_we && w_is_stat),
      .o_full        (w_full),
      .o_empty       (w_empty),
      .o_busy        (w_busy),
      .o_overrun     (w_ovr),
      .o_tx          (uart_tx)
   );

   // Status word assembly
   always_comb begin
      w_stat          = '0;
      w_stat[ST_FULL]  = w_full;
      w_stat[ST_EMPTY] = w_empty;
      w_stat[ST_BUSY]  = w_busy;
      w_stat[ST_OVR]   = w_ovr;
   end

   // Inferred RAM: synchronous read returns the pre-write word
   always_ff @(posedge clk) begin
      if (cpu_we && w_is_ram) r_ram[w_ram_idx] <= cpu_wdata;
      r_ram_q <= r_ram[w_ram_idx];
   end

   // Free-running tick counter; a write restarts it from zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  r_tick <= '0;
      else if (cpu_we && w_is_tick) r_tick <= '0;
      else                         r_tick <= r_tick + 1'b1;
   end

   // LED register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  r_led <= '0;
      else if (cpu_we && w_is_led) r_led <= cpu_wdata[7:0];
   end

   // Read-data registers: I/O values captured before this edge's update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sel_ram <= 1'b0;
         r_io_q    <= '0;
      end else begin
         r_sel_ram <= w_is_ram;
         unique case (1'b1)
            w_is_stat: r_io_q <= w_stat;
            w_is_tick: r_io_q <= r_tick;
            w_is_led:  r_io_q <= {8'h00, r_led};
            default:   r_io_q <= '0;
         endcase
      end
   end

   assign cpu_rdata = r_sel_ram ? r_ram_q : r_io_q;
   assign led       = r_led;

endmodule

// File: doc/fifth_memio.md
# fifth_memio

Data-memory responder for the fifth CPU core. It answers the core's data port (address, write enable, write data, read data) with on-chip RAM and a small memory-mapped I/O page: a UART transmitter with FIFO, a free-running tick counter and an LED register. It sits directly on the core's memory port. Reads are synchronous with one-cycle latency, which matches the core presenting its next-cycle address.

## Interface
- `RAM_AW`, default 13: RAM word-address width; 2^RAM_AW 16-bit words.
- `CLKS_PER_BIT`, default 217: clk cycles per UART bit.
- `FIFO_AW`, default 3: TX FIFO depth is 2^FIFO_AW bytes.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `cpu_addr`  in  16  byte address; bit 0 ignored.
- `cpu_we`  in  1  write strobe; write commits at the rising edge.
- `cpu_wdata`  in  16  write data.
- `cpu_rdata`  out  16  registered read data for the address sampled at the previous edge.
- `uart_tx`  out  1  serial line, 8N1, LSB first, idles high.
- `led`  out  8  LED register.

## Operation
- Address map (word = cpu_addr[15:1]):
  - 0x0000–0x7FFF: RAM, indexed by cpu_addr[RAM_AW:1]; aliases above the RAM size.
  - 0xF000 UART data: write pushes cpu_wdata[7:0]; reads return 0.
  - 0xF002 status: bit0 fifo full, bit1 fifo empty, bit2 tx busy (FSM not IDLE), bit3 overrun (sticky). A write of any value clears overrun.
  - 0xF004 tick counter: reads return the 16-bit count. A write loads 0.
  - 0xF006 LED: write loads cpu_wdata[7:0]; read returns {8'h00, led}.
  - All other addresses read 0; writes to them are ignored.
- RAM read-during-write to the same word returns the old data. RAM contents are not reset.
- Reads are side-effect free. I/O reads return values as they were before that edge's update.
- Tick counter increments every edge unless written, and wraps 0xFFFF→0.
- TX FIFO:
  - A push while full is dropped and sets overrun.
  - A pop and a push at the same edge are both honoured; a push when full succeeds if a pop occurs at that edge.
  - A pop occurs only if the FIFO is non-empty before the edge.
- TX FSM states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop, load the shifter, go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles, bit counter 0..7, then STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- The baud counter counts CLKS_PER_BIT-1 down to 0 per bit.

## Timing
- Reset values: cpu_rdata=0, uart_tx=1, led=0, FIFO empty, overrun=0, tick=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately: line high, queued bytes discarded.
- Read latency: the address present before edge E yields cpu_rdata valid after E, held until the next edge.
- Push at edge E0 with FSM idle: pop at E1, and uart_tx falls after E1. One frame is 10·CLKS_PER_BIT cycles.
- uart_tx is driven from a flop; no combinational path from the inputs.

## Structure
- Package `fifth_io_pkg` holds:
  - address constants UART_DATA, UART_STAT, TICK, LED;
  - status bit indices;
  - the TX state enum.
- Sub-module `fifth_uart_tx` contains FIFO, FSM, shifter and baud counter. Its interface is push/data/full/empty/busy/overrun/clr_overrun/tx.
- The top level holds address decode, the inferred RAM, the tick counter, the LED register and the cpu_rdata mux register.

## Test plan
- Write 0x1234 to 0x0010, then read 0x0010 → cpu_rdata=0x1234 one edge after sampling; reading 0x0011 also returns 0x1234.
- With CLKS_PER_BIT=4, write 0x0055 to 0xF000 → uart_tx falls one edge after the push. The line is then low 4 cycles, followed by data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; status bit2 clears after 40 cycles.
- Push 10 bytes on consecutive edges with the FSM idle → byte 0 is popped, bytes 1–8 fill the FIFO, byte 9 is dropped. Status reads 0x000D. A write to 0xF002 clears bit3, giving 0x0005.
- Write 0xF004 at edge E, with a read sampled at E+10 → 0x0009. Preload 0xFFFF by timing → the counter wraps to 0.
- Write 0x01A5 to 0xF006 → led=0xA5 and readback 0x00A5. A read of 0x9000 returns 0x0000.
- Assert reset during the DATA state → uart_tx=1 asynchronously; after release, status=0x0002 and cpu_rdata=0.
